// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : Moore control FSM for the multicycle RISC-V core
//   Optional feature macro: ILLEGAL_TRAP_EN (halt on unsupported encodings)
//   Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  localparam logic [6:0] c_OP_LW  = 7'b0000011;
  localparam logic [6:0] c_OP_SW  = 7'b0100011;
  localparam logic [6:0] c_OP_R   = 7'b0110011;
  localparam logic [6:0] c_OP_I   = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ = 7'b1100011;
  localparam logic [6:0] c_OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
    , S_HALT   = 4'd11
`endif
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_branch;
  logic       w_pcupdate;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_f3_legal;
`ifdef ILLEGAL_TRAP_EN
  logic       w_illegal;
`endif

  assign w_f3_legal = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_aluop    = 2'b00;
    w_branch   = 1'b0;
    w_pcupdate = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
`ifdef ILLEGAL_TRAP_EN
    w_illegal  = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_irwrite  = 1'b1;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        w_pcupdate = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          c_OP_LW, c_OP_SW: w_next = S_MEMADR;
          c_OP_R:           w_next = S_EXECR;
          c_OP_I:           w_next = S_EXECI;
          c_OP_BEQ:         w_next = S_BEQ;
          c_OP_JAL:         w_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:          w_next = S_HALT;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        w_next  = (op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_aluop = 2'b10;
`ifdef ILLEGAL_TRAP_EN
        w_next  = w_f3_legal ? S_ALUWB : S_HALT;
`else
        // Unsupported funct3 falls through as an add and still writes rd
        w_next  = S_ALUWB;
`endif
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BEQ: begin
        alusrca  = 2'b10;
        w_aluop  = 2'b01;
        w_branch = 1'b1;
        w_next   = S_FETCH;
      end
      S_JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        w_illegal = 1'b1;
        w_next    = S_HALT;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    case (w_aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b111:  alucontrol = 3'b010;
          3'b110:  alucontrol = 3'b011;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      c_OP_SW:  immsrc = 2'b01;
      c_OP_BEQ: immsrc = 2'b10;
      c_OP_JAL: immsrc = 2'b11;
      default:  immsrc = 2'b00;
    endcase
  end

  // Strobes are gated by rst_n so nothing is written while reset is low
  assign pcwrite  = rst_n & (w_pcupdate | (w_branch & zero));
  assign irwrite  = rst_n & w_irwrite;
  assign regwrite = rst_n & w_regwrite;
  assign memwrite = rst_n & w_memwrite;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = w_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed bench with an instruction-level output model
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [6:0] op       = 7'd0;
  logic [2:0] funct3   = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero     = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .immsrc(immsrc), .regwrite(regwrite),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic       rw;
    logic [2:0] alc;
    logic       ill;
  } rec_t;
  typedef rec_t rec_q_t[$];

  rec_t  exp_q[$];
  string tag_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic rec_t r(input logic pcw, adr, mw, irw, input logic [1:0] rs, asa, asb,
                             imm, input logic rw, input logic [2:0] alc, input logic ill);
    rec_t x;
    x.pcw = pcw; x.adr = adr; x.mw = mw; x.irw = irw; x.rs = rs; x.asa = asa;
    x.asb = asb; x.imm = imm; x.rw = rw; x.alc = alc; x.ill = ill;
    return x;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] arith(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b000 && o == 7'b0110011 && f7) return 3'b001;
    return 3'b000;
  endfunction

  function automatic rec_t rst_rec(input logic [6:0] o);
    return r(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm_of(o), 0, 3'b000, 0);
  endfunction

  // Expected per-cycle outputs for one whole instruction, starting at fetch
  function automatic rec_q_t build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int n_halt);
    rec_q_t     q;
    logic [1:0] im   = imm_of(o);
    bit         f3ok = (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
    bit         trapped = 1'b0;
    rec_t       aluwb  = r(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 1, 3'b000, 0);
    rec_t       memadr = r(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 0, 3'b000, 0);
    q.push_back(r(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, im, 0, 3'b000, 0));
    q.push_back(r(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 0, 3'b000, 0));
    case (o)
      7'b0000011: begin
        q.push_back(memadr);
        q.push_back(r(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'b000, 0));
        q.push_back(r(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, im, 1, 3'b000, 0));
      end
      7'b0100011: begin
        q.push_back(memadr);
        q.push_back(r(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'b000, 0));
      end
      7'b0110011, 7'b0010011: begin
        q.push_back(r(0, 0, 0, 0, 2'b00, 2'b10, (o == 7'b0010011) ? 2'b01 : 2'b00, im, 0,
                      arith(o, f3, f7), 0));
        if (TRAP && !f3ok) trapped = 1'b1;
        else q.push_back(aluwb);
      end
      7'b1100011: q.push_back(r(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, 0, 3'b001, 0));
      7'b1101111: begin
        q.push_back(r(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 0, 3'b000, 0));
        q.push_back(aluwb);
      end
      default: trapped = TRAP;
    endcase
    if (trapped)
      for (int i = 0; i < n_halt; i++)
        q.push_back(r(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 0, 3'b000, 1));
    return q;
  endfunction

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", nm, act, expv);
    end
  endtask

  // Compare process: model pins first, then every cycle against the queue
  initial begin : p_compare
    rec_q_t q;
    rec_t   act;
    q = build(7'b0000011, 3'b000, 1'b0, 1'b0, 0);
    chk("pin_lw_len", 17'(q.size()), 17'd5);
    chk("pin_lw_memwb", q[4], 17'b0_0_0_0_01_00_00_00_1_000_0);
    q = build(7'b0100011, 3'b010, 1'b0, 1'b0, 0);
    chk("pin_sw_len", 17'(q.size()), 17'd4);
    q = build(7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    chk("pin_beq_len", 17'(q.size()), 17'd3);
    chk("pin_beq_taken", q[2], 17'b1_0_0_0_00_10_00_10_0_001_0);
    q = build(7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    chk("pin_sub_exec", q[2], 17'b0_0_0_0_00_10_00_00_0_001_0);
    q = build(7'b1101111, 3'b000, 1'b0, 1'b0, 0);
    chk("pin_jal_len", 17'(q.size()), 17'd4);
    chk("pin_jal_exec", q[2], 17'b1_0_0_0_00_01_10_11_0_000_0);
    forever begin
      @(negedge clk or negedge rst_n);
      act = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, immsrc,
             regwrite, alucontrol, illegal};
      if (clk) begin
        // reset fell mid-cycle: strobes must drop without waiting for a clock
        #1;
        exp_q.delete();
        tag_q.delete();
        chk("async_rst_strobes", {13'd0, pcwrite, irwrite, regwrite, memwrite}, 17'd0);
      end else if (!rst_n) begin
        chk("reset_outputs", act, rst_rec(op));
      end else if (exp_q.size() > 0) begin
        chk(tag_q.pop_front(), act, exp_q.pop_front());
      end
    end
  end

  // cut > 0 asserts reset after that many cycles; trapped runs also end in reset
  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input int n_halt, input int cut);
    rec_q_t q = build(o, f3, f7, z, n_halt);
    int     n = (cut > 0) ? cut : q.size();
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (q[i]) begin
      exp_q.push_back(q[i]);
      tag_q.push_back($sformatf("%s.c%0d", nm, i + 1));
    end
    repeat (n) @(posedge clk);
    #1;
    if (cut > 0 || q[q.size()-1].ill) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
  endtask

  initial begin : p_stim
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
    run("sw",      7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0);
    run("add",     7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    run("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    run("or",      7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
    run("and",     7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0);
    run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
    run("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);
    run("beq_tk",  7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    run("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    run("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
    run("bad_op",  7'b1111111, 3'b000, 1'b0, 1'b0, 10, 0);
    run("bad_f3",  7'b0110011, 3'b001, 1'b0, 1'b0, 3, 0);
    run("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 4);
    run("sw_after", 7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0);
    run("beq_last", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
